// File: rtl/data_memory_responder.sv
// Multi-cycle word-addressed data memory answering MEM-stage load/store requests.
// One request at a time over req/ack, fixed access latency, combinational pipeline stall.
module data_memory_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [31:0]     mem_q [DEPTH];

  logic            access;
  logic            addr_err;
  logic            mem_we;
  logic [IdxW-1:0] idx;

  // Any address bit above the array span means out of range.
  assign idx      = addr_q[IdxW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:IdxW+2] != '0);
  assign access   = (state_q == StBusy) && (cnt_q == '0);
  assign mem_we   = access && we_q && !addr_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StResp;
          ack_d   = 1'b1;
          if (addr_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (!we_q) begin
            rdata_d = mem_q[idx];
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IdxW'(i)] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (mem_we) begin
        mem_q[idx] <= wdata_q;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign stall_o = ((state_q == StIdle) && req_i) || (state_q == StBusy);

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: vector table plus hand-written corner sequences,
// with expected responses queued at request time and checked when ack_o arrives.
module tb_data_memory_responder;

  localparam int unsigned Latency = 3;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  data_memory_responder #(
    .DEPTH  (32),
    .LATENCY(Latency)
  ) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .ack_o  (ack),
    .err_o  (err),
    .stall_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("err", 32'(err), 32'(e.err));
      end
    end
  end

  // Issue one request, check latency, stall profile and single-cycle ack.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input bit mutate);
    exp_t e;
    int   k;
    bit   stall_ok;
    e.rdata = er;
    e.err   = ee;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    k = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (stall !== ((k <= int'(Latency)) ? 1'b1 : 1'b0)) stall_ok = 1'b0;
      if (ack === 1'b1) break;
      if (k > 40) break;
      if (mutate && k == 0) begin
        @(posedge clk); #1;
        addr = 32'h14; wdata = 32'h0;
      end
      k++;
    end
    check("ack_latency", 32'(k), 32'(Latency + 1));
    check("stall_profile", 32'(stall_ok), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("ack_width", 32'(ack), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h06, 32'h12345678, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 32'h04, 32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h80, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b1, 32'h7C, 32'h11223344, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h7C, 32'h0,        32'h11223344, 1'b0};
    vecs[7]  = '{1'b1, 32'h00, 32'h5555AAAA, 32'h11223344, 1'b0};
    vecs[8]  = '{1'b0, 32'h00, 32'h0,        32'h5555AAAA, 1'b0};
    vecs[9]  = '{1'b0, 32'h01, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'hFFFFFFFC, 32'h9, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end

    // Inputs changed during BUSY must not affect the captured store.
    do_req(1'b1, 32'h10, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    do_req(1'b0, 32'h14, 32'h0, 32'h00000000, 1'b0, 1'b0);

    // Back-to-back with req held high: acks in cycles 4 and 9.
    begin
      exp_t e;
      logic [9:0] ack_v, stall_v;
      e.rdata = 32'hDEADBEEF; e.err = 1'b0; exp_q.push_back(e);
      e.rdata = 32'h0;        e.err = 1'b0; exp_q.push_back(e);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 32'h08; wdata = '0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        ack_v[k]   = ack;
        stall_v[k] = stall;
        if (k == 4) begin
          @(posedge clk); #1;
          addr = 32'h0C;
        end
      end
      @(posedge clk); #1;
      req = 1'b0;
      check("b2b_ack", 32'(ack_v), 32'h210);
      check("b2b_stall", 32'(stall_v), 32'h1EF);
    end

    // Reset mid-BUSY: outputs clear at once, no ack, store never lands.
    do_req(1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    req = 1'b0;
    #1;
    check("arst_rdata", rdata, 32'h0);
    check("arst_ack", 32'(ack), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("arst_no_pending", 32'(exp_q.size()), 32'd0);
    do_req(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Multi-cycle data-memory target that answers the MEM-stage load/store requests issued by the CPU pipeline.
- Holds a word-addressed array. It accepts one request at a time over a req/ack handshake, waits a configurable access latency, then completes the request.
- Drives a stall signal so the pipeline can freeze its earlier stages while an access is in flight.

Parameters:
- DEPTH, 32: number of 32-bit words in the array; power of two, at least 2.
- LATENCY, 3: wait cycles spent in BUSY per access; must be at least 1.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_i  input  1  request valid; the initiator holds it high until it samples ack_o=1.
- we_i  input  1  1 = store, 0 = load.
- addr_i  input  32  byte address.
- wdata_i  input  32  store data.
- rdata_o  output  32  load data; registered.
- ack_o  output  1  completion pulse, exactly one cycle wide.
- err_o  output  1  error flag; valid only while ack_o=1.
- stall_o  output  1  pipeline stall request; combinational.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0.
  - ack_o=0, err_o=0, rdata_o=0.
  - All DEPTH words cleared to 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req_i=1: capture we_i, addr_i and wdata_i into internal registers, load counter=LATENCY-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; only the captured values are used.
  - If counter≠0: decrement counter.
  - If counter=0: perform the access at this edge and go to RESP.
- Access performed at the BUSY→RESP edge:
  - Word index = captured addr[log2(DEPTH)+1:2].
  - Error condition: addr[1:0]≠0, or addr ≥ DEPTH*4.
  - On error: no array write; rdata_o←0; err_o←1.
  - Valid store: array[index]←wdata; rdata_o unchanged; err_o←0.
  - Valid load: rdata_o←array[index]; err_o←0.
- RESP:
  - ack_o=1 for this single cycle; then unconditionally go to IDLE.
  - req_i is ignored here, because it still belongs to the completed request.
- ack_o and err_o are registered. They are 1 only in RESP; err_o is 0 whenever ack_o=0.
- stall_o = (state==IDLE && req_i) || (state==BUSY).
  - It is 0 in RESP, so the pipeline advances on the edge where ack_o=1.
- Latency:
  - Request first seen in IDLE at cycle 0 → ack_o=1 in cycle LATENCY+1.
  - stall_o=1 in cycles 0..LATENCY.
- Back-to-back: if req_i is still 1 in the IDLE cycle after RESP, it is a new request and is accepted. Turnaround is therefore one IDLE cycle.
- rdata_o holds its value until the next completed load or erroring access.
- Reset mid-operation: the transaction is aborted, no array write occurs, and no ack is issued. A store is only committed at the BUSY→RESP edge.
- Only full-word accesses are supported; there are no byte enables.

Test Plan:
- Store then load, LATENCY=3:
  - Stimulus: req store addr 0x08 data 0xDEADBEEF, then a load of 0x08.
  - Response: each ack_o in cycle 4 after request; stall_o high in cycles 0-3; load returns rdata_o=0xDEADBEEF with err_o=0.
- Misaligned store:
  - Stimulus: store 0x12345678 to addr 0x06, then load 0x04.
  - Response: first ack_o has err_o=1; load returns 0x00000000 with err_o=0, proving no write occurred.
- Out-of-range load, DEPTH=32:
  - Stimulus: load addr 0x80.
  - Response: ack_o with err_o=1 and rdata_o=0.
- Input change during BUSY:
  - Stimulus: store 0xA5A5A5A5 to 0x10; change addr_i to 0x14 and wdata_i to 0 in cycle 1; then load 0x10 and load 0x14.
  - Response: loads return 0xA5A5A5A5 and 0x00000000 respectively.
- Reset during BUSY:
  - Stimulus: store 0xCAFEF00D to 0x0C; pulse rst_i in cycle 2.
  - Response: outputs drop to 0 asynchronously and no ack_o appears; after reset, load 0x0C returns 0.
- Back-to-back requests:
  - Stimulus: hold req_i=1 continuously; load 0x08, then switch to load 0x0C at the ack edge.
  - Response: ack_o pulses in cycles 4 and 9; stall_o=0 only in cycles 4 and 9.
